quantdeser: RTL

QUANTDESER -- requirements
Module: quantdeser

---
 rtl/quantdeser.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/quantdeser.sv
// Bit-serial multi-lane deserializer: N lanes shift in words of bwin+1 bits
// (MSB first) and hand completed word sets to a single-entry output register.

module quantdeser_chk #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         clr,
  input logic         ready,
  input logic         valid,
  input logic         overrun,
  input logic [W-1:0] dout
);

  // Sticky overrun only falls through clr.
  a_overrun_sticky: assert property (@(posedge clk) (!clr && overrun) |=> overrun);

  // A held word stays put until it is taken.
  a_hold_stable: assert property (@(posedge clk) (!clr && valid && !ready) |=> (valid && $stable(dout)));

endmodule

module quantdeser #(
  parameter int N      = 64,
  parameter int BWIN   = 32,
  parameter int BWBWIN = $clog2(BWIN)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [BWBWIN-1:0]   bwin,
  input  logic                start,
  input  logic                stall,
  input  logic [N-1:0]        din,
  input  logic                ready,
  output logic                valid,
  output logic [N*BWIN-1:0]   dout,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [BWBWIN-1:0] CNT_ONE  = BWBWIN'(1);
  localparam logic [BWBWIN-1:0] CNT_ZERO = BWBWIN'(0);

  state_e                     state_q, state_d;
  logic [BWBWIN-1:0]          cnt_q, cnt_d;
  logic [N-1:0][BWIN-1:0]     shreg_q, shreg_d;
  logic                       valid_q, valid_d;
  logic [N*BWIN-1:0]          dout_q, dout_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;
  logic                       accept_s;
  logic                       comp_s;

  assign accept_s = ~clr & ~stall;

  // Input side: word assembly FSM, counter and per-lane shift registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    comp_s  = 1'b0;
    if (accept_s) begin
      if (start) begin
        for (int i = 0; i < N; i++) begin
          shreg_d[i] = {{(BWIN-1){1'b0}}, din[i]};
        end
        cnt_d = bwin;
        if (bwin == CNT_ZERO) begin
          state_d = IDLE;
          comp_s  = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end else begin
        case (state_q)
          SHIFT: begin
            for (int i = 0; i < N; i++) begin
              shreg_d[i] = {shreg_q[i][BWIN-2:0], din[i]};
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = IDLE;
              comp_s  = 1'b1;
            end else begin
              state_d = SHIFT;
            end
          end
          IDLE: begin
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output side: holding register handshake, independent of stall.
  always_comb begin
    valid_d   = valid_q;
    dout_d    = dout_q;
    overrun_d = overrun_q;
    busy_d    = (state_d == SHIFT);
    if (comp_s && (!valid_q || ready)) begin
      valid_d = 1'b1;
      dout_d  = shreg_d;
    end else if (comp_s) begin
      overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign dout    = dout_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

  quantdeser_chk #(
    .W(N*BWIN)
  ) u_chk (
    .clk     (clk),
    .clr     (clr),
    .ready   (ready),
    .valid   (valid_q),
    .overrun (overrun_q),
    .dout    (dout_q)
  );

endmodule
